core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl_pkg.sv | 91 +++++++++
 rtl/core_ctrl_dec.sv | 36 +++
 rtl/core_ctrl.sv | 171 +++++++++++++++++
 tb/tb_core_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - RV32I control-core shared ISA types, opcodes, FSM states and wb_sel encoding
package core_ctrl_pkg;

   // Base opcodes handled by the control core
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Writeback source select
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_t;

   typedef enum logic [3:0] {
      CLS_LUI,
      CLS_AUIPC,
      CLS_JAL,
      CLS_JALR,
      CLS_BRANCH,
      CLS_LOAD,
      CLS_STORE,
      CLS_OP_IMM,
      CLS_OP,
      CLS_MISC_MEM,
      CLS_ILLEGAL
   } inst_class_t;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } r_type_t;

   typedef struct packed {
      logic [11:0] imm;
      logic [4:0]  rs1;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [6:0]  opcode;
   } i_type_t;

   typedef struct packed {
      logic [6:0] imm_hi;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] imm_lo;
      logic [6:0] opcode;
   } s_type_t;

   typedef struct packed {
      logic [19:0] imm;
      logic [4:0]  rd;
      logic [6:0]  opcode;
   } u_type_t;

   typedef union packed {
      r_type_t     r;
      i_type_t     i;
      s_type_t     s;
      u_type_t     u;
      logic [31:0] raw;
   } rv32i_inst_t;

   // Sequential PC step; the 32-bit sum wraps naturally past FFFF_FFFC
   function automatic logic [31:0] pc_plus4(input logic [31:0] a);
      return a + 32'd4;
   endfunction

endpackage

// File: rtl/core_ctrl_dec.sv
// rtl/core_ctrl_dec.sv - combinational RV32I opcode classifier with illegal flag
module core_ctrl_dec
   import core_ctrl_pkg::*;
(
   input  rv32i_inst_t inst,
   output inst_class_t cls,
   output logic        illegal,
   output logic        rd_zero
);

   // Only opcode and rd steer the controller; the remaining fields belong to the datapath
   logic unused_fields;
   assign unused_fields = ^{inst.r.funct7, inst.r.rs2, inst.r.rs1, inst.r.funct3};

   // Map the opcode field onto an instruction class; SYSTEM and unknowns are illegal
   always_comb begin
      cls = CLS_ILLEGAL;
      case (inst.r.opcode)
         OPC_LUI:      cls = CLS_LUI;
         OPC_AUIPC:    cls = CLS_AUIPC;
         OPC_JAL:      cls = CLS_JAL;
         OPC_JALR:     cls = CLS_JALR;
         OPC_BRANCH:   cls = CLS_BRANCH;
         OPC_LOAD:     cls = CLS_LOAD;
         OPC_STORE:    cls = CLS_STORE;
         OPC_OP_IMM:   cls = CLS_OP_IMM;
         OPC_OP:       cls = CLS_OP;
         OPC_MISC_MEM: cls = CLS_MISC_MEM;
         default:      cls = CLS_ILLEGAL;
      endcase
   end

   assign illegal = (cls == CLS_ILLEGAL);
   assign rd_zero = (inst.r.rd == 5'd0);

endmodule

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - multi-cycle RV32I control FSM with PC, IR and retired-instruction counter
module core_ctrl
   import core_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ifu_req,
   output logic [31:0] ifu_addr,
   input  logic        ifu_ack,
   input  logic [31:0] ifu_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   input  logic        br_taken,
   input  logic [31:0] tgt_pc,
   input  logic        instret_wr,
   input  logic [31:0] instret_wdata,
   output logic [31:0] pc,
   output rv32i_inst_t ir,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        trap,
   output logic [31:0] instret
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   rv32i_inst_t ir_q;
   logic [31:0] instret_q;
   logic        trap_q;
   logic [31:0] tgt_q;

   logic        ir_ld;
   logic        tgt_ld;
   logic        retire;
   logic        misalign;
   logic [31:0] pc4;

   inst_class_t cls;
   logic        illegal;
   logic        rd_zero;

   core_ctrl_dec u_dec (
      .inst    (ir_q),
      .cls     (cls),
      .illegal (illegal),
      .rd_zero (rd_zero)
   );

   assign pc4      = pc_plus4(pc_q);
   assign misalign = (tgt_pc[1:0] != 2'b00);

   // Next-state, PC update and handshake/strobe outputs, all decoded from the current state
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_ld    = 1'b0;
      tgt_ld   = 1'b0;
      retire   = 1'b0;
      ifu_req  = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = WB_ALU;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            ifu_req = 1'b1;
            if (ifu_ack) begin
               ir_ld   = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = illegal ? ST_TRAP : ST_EXEC;
         ST_EXEC: begin
            case (cls)
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               CLS_BRANCH: begin
                  if (br_taken && misalign) begin
                     state_d = ST_TRAP;
                  end else begin
                     pc_d    = br_taken ? tgt_pc : pc4;
                     retire  = 1'b1;
                     state_d = ST_FETCH;
                  end
               end
               CLS_MISC_MEM: begin
                  pc_d    = pc4;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
               CLS_JAL, CLS_JALR: begin
                  // Jump target is captured now but only committed to pc in WB
                  if (misalign) begin
                     state_d = ST_TRAP;
                  end else begin
                     tgt_ld  = 1'b1;
                     state_d = ST_WB;
                  end
               end
               default: state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls == CLS_STORE);
            if (dmem_ack) begin
               if (cls == CLS_STORE) begin
                  pc_d    = pc4;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            rf_we = !rd_zero;
            if (cls == CLS_LOAD) begin
               wb_sel = WB_MEM;
            end else if (cls == CLS_JAL || cls == CLS_JALR) begin
               wb_sel = WB_PC4;
            end
            pc_d    = (cls == CLS_JAL || cls == CLS_JALR) ? tgt_q : pc4;
            retire  = 1'b1;
            state_d = ST_FETCH;
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, PC, IR, jump-target latch, retire counter and sticky trap flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         instret_q <= '0;
         trap_q    <= 1'b0;
         tgt_q     <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (ir_ld) begin
            ir_q <= ifu_rdata;
         end
         if (tgt_ld) begin
            tgt_q <= tgt_pc;
         end
         // Counter preload wins over a same-cycle retire; a halted core keeps its count
         if (instret_wr && state_q != ST_TRAP) begin
            instret_q <= instret_wdata;
         end else if (retire) begin
            instret_q <= instret_q + 32'd1;
         end
         if (state_d == ST_TRAP) begin
            trap_q <= 1'b1;
         end
      end
   end

   assign ifu_addr = pc_q;
   assign pc       = pc_q;
   assign ir       = ir_q;
   assign instret  = instret_q;
   assign trap     = trap_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - directed table-driven bench for core_ctrl
module tb_core_ctrl;
   import core_ctrl_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        ifu_ack;
   logic [31:0] ifu_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        br_taken;
   logic [31:0] tgt_pc;
   logic        instret_wr;
   logic [31:0] instret_wdata;
   logic [31:0] pc;
   rv32i_inst_t ir;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic        trap;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;

   core_ctrl #(.RESET_PC(32'h0000_0100)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ifu_req       (ifu_req),
      .ifu_addr      (ifu_addr),
      .ifu_ack       (ifu_ack),
      .ifu_rdata     (ifu_rdata),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_ack      (dmem_ack),
      .br_taken      (br_taken),
      .tgt_pc        (tgt_pc),
      .instret_wr    (instret_wr),
      .instret_wdata (instret_wdata),
      .pc            (pc),
      .ir            (ir),
      .rf_we         (rf_we),
      .wb_sel        (wb_sel),
      .trap          (trap),
      .instret       (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic        br;
      logic [31:0] tgt;
      int          mem_wait;
      logic        noise;
      int          exp_cycles;
      logic        exp_rfw;
      logic [1:0]  exp_wbs;
      int          exp_memc;
      logic        exp_mwe;
      logic [31:0] exp_pc;
      logic [31:0] exp_instret;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ifu_ack = 1'b0;
      dmem_ack = 1'b0;
      instret_wr = 1'b0;
      br_taken = 1'b0;
      tgt_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_fetch();
      int n = 0;
      while (!ifu_req && n < 8) begin
         step();
         n++;
      end
      check("fetch_reached", {31'd0, ifu_req}, 32'd1);
   endtask

   // Runs one instruction from FETCH with a same-cycle fetch ack; EXEC is always the third cycle
   task automatic run_inst(input logic [31:0] inst, input logic br, input logic [31:0] tgt,
                           input int mem_wait, input logic noise,
                           output int cycles, output logic rfw, output logic [1:0] wbs,
                           output int memc, output logic mwe);
      int   waitc = 0;
      logic done = 1'b0;
      cycles = 0;
      rfw = 1'b0;
      wbs = 2'd0;
      memc = 0;
      mwe = 1'b0;
      for (int c = 0; c < 40; c++) begin
         ifu_ack   = ifu_req | noise;
         ifu_rdata = ifu_req ? inst : 32'h0000_0073;
         br_taken  = (c == 2) ? br : 1'b1;
         tgt_pc    = (c == 2) ? tgt : 32'h0000_0FF3;
         if (dmem_req) begin
            memc++;
            mwe = dmem_we;
            dmem_ack = (waitc == mem_wait);
            waitc++;
         end else begin
            dmem_ack = noise;
         end
         if (rf_we) rfw = 1'b1;
         wbs = wbs | wb_sel;
         cycles++;
         step();
         if (ifu_req || trap) begin
            done = 1'b1;
            break;
         end
      end
      ifu_ack = 1'b0;
      dmem_ack = 1'b0;
      br_taken = 1'b0;
      tgt_pc = '0;
      check("inst_done", {31'd0, done}, 32'd1);
   endtask

   initial begin
      int          cyc;
      int          memc;
      logic        rfw;
      logic        mwe;
      logic [1:0]  wbs;
      logic [31:0] prev_pc;

      //            inst          br    tgt           mw noise cyc rfw wbs memc mwe  pc            instret
      vecs[0]  = '{32'h0010_0293, 1'b0, 32'h0000_0000, 0, 1'b1, 4, 1'b1, 2'd0, 0, 1'b0, 32'h0000_0104, 32'd1};
      vecs[1]  = '{32'h0000_2183, 1'b0, 32'h0000_0000, 3, 1'b0, 8, 1'b1, 2'd1, 4, 1'b0, 32'h0000_0108, 32'd2};
      vecs[2]  = '{32'h0000_2023, 1'b0, 32'h0000_0000, 0, 1'b1, 4, 1'b0, 2'd0, 1, 1'b1, 32'h0000_010C, 32'd3};
      vecs[3]  = '{32'h0000_0063, 1'b1, 32'h0000_0200, 0, 1'b0, 3, 1'b0, 2'd0, 0, 1'b0, 32'h0000_0200, 32'd4};
      vecs[4]  = '{32'h0000_0063, 1'b0, 32'h0000_0300, 0, 1'b0, 3, 1'b0, 2'd0, 0, 1'b0, 32'h0000_0204, 32'd5};
      vecs[5]  = '{32'h0000_000F, 1'b0, 32'h0000_0000, 0, 1'b0, 3, 1'b0, 2'd0, 0, 1'b0, 32'h0000_0208, 32'd6};
      vecs[6]  = '{32'h1234_53B7, 1'b0, 32'h0000_0000, 0, 1'b0, 4, 1'b1, 2'd0, 0, 1'b0, 32'h0000_020C, 32'd7};
      vecs[7]  = '{32'h0000_0097, 1'b0, 32'h0000_0000, 0, 1'b0, 4, 1'b1, 2'd0, 0, 1'b0, 32'h0000_0210, 32'd8};
      vecs[8]  = '{32'h0000_00EF, 1'b0, 32'h0000_0400, 0, 1'b1, 4, 1'b1, 2'd2, 0, 1'b0, 32'h0000_0400, 32'd9};
      vecs[9]  = '{32'h0000_0067, 1'b0, 32'h0000_0500, 0, 1'b0, 4, 1'b0, 2'd2, 0, 1'b0, 32'h0000_0500, 32'd10};
      vecs[10] = '{32'h0000_0033, 1'b0, 32'h0000_0000, 0, 1'b0, 4, 1'b0, 2'd0, 0, 1'b0, 32'h0000_0504, 32'd11};
      vecs[11] = '{32'h0000_0063, 1'b1, 32'hFFFF_FFFC, 0, 1'b0, 3, 1'b0, 2'd0, 0, 1'b0, 32'hFFFF_FFFC, 32'd12};
      vecs[12] = '{32'h0010_0293, 1'b0, 32'h0000_0000, 0, 1'b0, 4, 1'b1, 2'd0, 0, 1'b0, 32'h0000_0000, 32'd13};
      vecs[13] = '{32'h0000_0063, 1'b0, 32'h0000_0203, 0, 1'b0, 3, 1'b0, 2'd0, 0, 1'b0, 32'h0000_0004, 32'd14};

      ifu_rdata = '0;
      instret_wdata = '0;
      do_reset();

      check("rst_ifu_req", {31'd0, ifu_req}, 32'd0);
      check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check("rst_wb_sel", {30'd0, wb_sel}, 32'd0);
      check("rst_trap", {31'd0, trap}, 32'd0);
      check("rst_pc", pc, 32'h0000_0100);
      check("rst_instret", instret, 32'd0);
      check("rst_ir", ir, 32'd0);
      step();
      check("idle_one_cycle", {31'd0, ifu_req}, 32'd1);

      prev_pc = 32'h0000_0100;
      for (int v = 0; v < 14; v++) begin
         check($sformatf("v%0d_ifu_addr", v), ifu_addr, prev_pc);
         run_inst(vecs[v].inst, vecs[v].br, vecs[v].tgt, vecs[v].mem_wait, vecs[v].noise,
                  cyc, rfw, wbs, memc, mwe);
         check($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cycles);
         check($sformatf("v%0d_rf_we", v), {31'd0, rfw}, {31'd0, vecs[v].exp_rfw});
         check($sformatf("v%0d_wb_sel", v), {30'd0, wbs}, {30'd0, vecs[v].exp_wbs});
         check($sformatf("v%0d_mem_cycles", v), memc, vecs[v].exp_memc);
         check($sformatf("v%0d_dmem_we", v), {31'd0, mwe}, {31'd0, vecs[v].exp_mwe});
         check($sformatf("v%0d_pc", v), pc, vecs[v].exp_pc);
         check($sformatf("v%0d_instret", v), instret, vecs[v].exp_instret);
         check($sformatf("v%0d_trap", v), {31'd0, trap}, 32'd0);
         prev_pc = vecs[v].exp_pc;
      end

      // Counter preload to all-ones, then one retire wraps it to zero
      instret_wr = 1'b1;
      instret_wdata = 32'hFFFF_FFFF;
      step();
      instret_wr = 1'b0;
      check("preload_instret", instret, 32'hFFFF_FFFF);
      check("preload_fetch_held", {31'd0, ifu_req}, 32'd1);
      run_inst(32'h0000_0033, 1'b0, 32'h0, 0, 1'b0, cyc, rfw, wbs, memc, mwe);
      check("wrap_instret", instret, 32'd0);
      check("wrap_rd0_rf_we", {31'd0, rfw}, 32'd0);
      check("wrap_pc", pc, 32'h0000_0008);

      // Reset while MEM waits for an ack; a late ack after release is ignored
      ifu_ack = 1'b1;
      ifu_rdata = 32'h0000_2183;
      step();
      ifu_ack = 1'b0;
      step();
      step();
      check("mem_req_before_rst", {31'd0, dmem_req}, 32'd1);
      rst_n = 1'b0;
      step();
      check("mem_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("mem_rst_ifu_req", {31'd0, ifu_req}, 32'd0);
      check("mem_rst_pc", pc, 32'h0000_0100);
      rst_n = 1'b1;
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      check("mem_rst_fetch", {31'd0, ifu_req}, 32'd1);
      check("mem_rst_dmem_idle", {31'd0, dmem_req}, 32'd0);
      check("mem_rst_instret", instret, 32'd0);

      // Reset during FETCH with ack withheld, ack pulsed in the release cycle
      step();
      step();
      check("fetch_hold_req", {31'd0, ifu_req}, 32'd1);
      check("fetch_hold_addr", ifu_addr, 32'h0000_0100);
      rst_n = 1'b0;
      step();
      check("fetch_rst_req", {31'd0, ifu_req}, 32'd0);
      rst_n = 1'b1;
      ifu_ack = 1'b1;
      ifu_rdata = 32'h0000_0073;
      check("release_idle", {31'd0, ifu_req}, 32'd0);
      step();
      ifu_ack = 1'b0;
      check("release_fetch", {31'd0, ifu_req}, 32'd1);
      check("release_ir", ir, 32'd0);
      check("release_pc", pc, 32'h0000_0100);
      step();
      check("release_fetch_held", {31'd0, ifu_req}, 32'd1);
      check("release_ir_held", ir, 32'd0);

      // Misaligned JAL target traps in EXEC; the trap state is absorbing
      run_inst(32'h0000_00EF, 1'b0, 32'h0000_0202, 0, 1'b0, cyc, rfw, wbs, memc, mwe);
      check("jal_trap_cycles", cyc, 3);
      check("jal_trap", {31'd0, trap}, 32'd1);
      check("jal_trap_pc", pc, 32'h0000_0100);
      check("jal_trap_instret", instret, 32'd0);
      check("jal_trap_rf_we", {31'd0, rfw}, 32'd0);
      instret_wr = 1'b1;
      instret_wdata = 32'd5;
      ifu_ack = 1'b1;
      dmem_ack = 1'b1;
      repeat (3) step();
      instret_wr = 1'b0;
      ifu_ack = 1'b0;
      dmem_ack = 1'b0;
      check("trap_ifu_req", {31'd0, ifu_req}, 32'd0);
      check("trap_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("trap_rf_we", {31'd0, rf_we}, 32'd0);
      check("trap_sticky", {31'd0, trap}, 32'd1);
      check("trap_pc_frozen", pc, 32'h0000_0100);
      check("trap_ir_frozen", ir, 32'h0000_00EF);
      check("trap_instret_frozen", instret, 32'd0);

      // SYSTEM opcode traps straight from DECODE
      do_reset();
      check("sys_rst_trap", {31'd0, trap}, 32'd0);
      wait_fetch();
      run_inst(32'h0000_0073, 1'b0, 32'h0, 0, 1'b0, cyc, rfw, wbs, memc, mwe);
      check("sys_trap_cycles", cyc, 2);
      check("sys_trap", {31'd0, trap}, 32'd1);
      check("sys_trap_pc", pc, 32'h0000_0100);

      // Taken branch to a misaligned target traps without retiring
      do_reset();
      wait_fetch();
      run_inst(32'h0000_0063, 1'b1, 32'h0000_0201, 0, 1'b0, cyc, rfw, wbs, memc, mwe);
      check("br_trap_cycles", cyc, 3);
      check("br_trap", {31'd0, trap}, 32'd1);
      check("br_trap_pc", pc, 32'h0000_0100);
      check("br_trap_instret", instret, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
